// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute sequencer: read operands, drive the ALU, write the result back to rs.
// Optional ITER_SHIFT_EN: reg-shamt instructions run as repeated shift-by-1 through a SHIFT state.
module alu_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 22
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [4:0]        rf_ra1,
  output logic [4:0]        rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [3:0]        alu_fcode,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y,
  output logic              rf_we,
  output logic [4:0]        rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              busy,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {IDLE, READ, EXEC, SHIFT, WB, FAULT} state_e;

  state_e            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] res_q, res_d;

  logic [2:0]        opcode;
  logic [4:0]        rs, rt, shamt;
  logic [3:0]        fcode;
  logic              is_rr, is_ri, is_rs;
  logic [DATA_W-1:0] imm_ext, class_b;

  assign opcode  = instr_q[31:29];
  assign rs      = instr_q[28:24];
  assign rt      = instr_q[23:19];
  assign shamt   = instr_q[18:14];
  assign fcode   = instr_q[3:0];
  assign is_ri   = (opcode == 3'd1);
  assign is_rr   = (opcode == 3'd0) && (fcode inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd9});
  assign is_rs   = (opcode == 3'd0) && !is_rr;
  assign imm_ext = {{(DATA_W-IMM_W){instr_q[IMM_W-1]}}, instr_q[IMM_W-1:0]};
  assign class_b = is_ri ? imm_ext : (is_rs ? DATA_W'(shamt) : op_b_q);

`ifdef ITER_SHIFT_EN
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
`ifdef ITER_SHIFT_EN
      acc_q   <= '0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
`ifdef ITER_SHIFT_EN
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  // Illegal opcodes are caught straight off the incoming word so FAULT lands in cycle 1.
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
`ifdef ITER_SHIFT_EN
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = (instr[31:29] > 3'd1) ? FAULT : READ;
        end
      end
      READ: begin
        op_a_d  = rf_rd1;
        op_b_d  = rf_rd2;
        state_d = EXEC;
`ifdef ITER_SHIFT_EN
        acc_d   = rf_rd1;
        cnt_d   = shamt;
        if (is_rs && (shamt != 5'd0)) state_d = SHIFT;
`endif
      end
      EXEC: begin
        res_d   = alu_y;
        state_d = WB;
      end
      SHIFT: begin
`ifdef ITER_SHIFT_EN
        // After the last shift-by-1, one EXEC with alu_b=0 moves acc into res.
        acc_d = alu_y;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = EXEC;
`else
        state_d = IDLE;
`endif
      end
      WB:      state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state_q == IDLE);
    busy        = (state_q != IDLE);
    rf_ra1      = '0;
    rf_ra2      = '0;
    alu_fcode   = '0;
    alu_a       = '0;
    alu_b       = '0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      READ: begin
        rf_ra1 = rs;
        rf_ra2 = rt;
      end
      EXEC: begin
        alu_fcode = fcode;
        alu_a     = op_a_q;
        alu_b     = class_b;
`ifdef ITER_SHIFT_EN
        if (is_rs) begin
          alu_a = acc_q;
          alu_b = DATA_W'(cnt_q);
        end
`endif
      end
      SHIFT: begin
`ifdef ITER_SHIFT_EN
        alu_fcode = fcode;
        alu_a     = acc_q;
        alu_b     = DATA_W'(1);
`endif
      end
      WB: begin
        rf_we = 1'b1;
        rf_wa = rs;
        rf_wd = res_q;
        done  = 1'b1;
      end
      FAULT: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl (default build, ITER_SHIFT_EN undefined).
// Directed vector table, hand-written handshake/reset sequences, then random instructions vs. a reference model.
module tb_alu_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [4:0]  rf_ra1, rf_ra2;
   logic [31:0] rf_rd1, rf_rd2;
   logic [3:0]  alu_fcode;
   logic [31:0] alu_a, alu_b, alu_y;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        busy, done, illegal;

   int testsRun = 0;
   int testsFailed = 0;

   // Register file contents are owned by the main stimulus process only; reads are combinational.
   logic [31:0] rf [32];

   typedef struct {
      logic [31:0] ins;
      logic [31:0] rsVal;
      logic [31:0] rtVal;
      logic [31:0] expB;
      logic [31:0] expWd;
      logic        ill;
   } vec_t;

   vec_t vecs [14];

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Environment ALU: a plain functional unit keyed on the function code
   function automatic logic [31:0] aluRef(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a << b[4:0];
         4'd5:    return a >> b[4:0];
         4'd6:    return a ^ b;
         4'd7:    return ~(a | b);
         4'd8:    return $signed(a) >>> b[4:0];
         4'd9:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return a + b;
      endcase
   endfunction

   assign rf_rd1 = rf[rf_ra1];
   assign rf_rd2 = rf[rf_ra2];
   assign alu_y  = aluRef(alu_fcode, alu_a, alu_b);

   alu_exec_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instr       (instr),
      .rf_ra1      (rf_ra1),
      .rf_ra2      (rf_ra2),
      .rf_rd1      (rf_rd1),
      .rf_rd2      (rf_rd2),
      .alu_fcode   (alu_fcode),
      .alu_a       (alu_a),
      .alu_b       (alu_b),
      .alu_y       (alu_y),
      .rf_we       (rf_we),
      .rf_wa       (rf_wa),
      .rf_wd       (rf_wd),
      .busy        (busy),
      .done        (done),
      .illegal     (illegal)
   );

   // Register-format word: opcode, rs, rt, shamt, fcode
   function automatic logic [31:0] mkR(input int op, input int rs, input int rt, input int sh, input int f);
      return {op[2:0], rs[4:0], rt[4:0], sh[4:0], 10'b0, f[3:0]};
   endfunction

   // Immediate-format word: opcode, rs, 22-bit immediate
   function automatic logic [31:0] mkI(input int op, input int rs, input int imm);
      return {op[2:0], rs[4:0], 2'b00, imm[21:0]};
   endfunction

   // Reference model: derives operand B, the written value and the illegal flag from the instruction rules
   function automatic void refModel(input logic [31:0] ins, input logic [31:0] aVal, input logic [31:0] rtVal,
                                    output logic [31:0] expB, output logic [31:0] expWd, output logic ill);
      int     op;
      int     f;
      longint immVal;
      op    = int'(ins[31:29]);
      f     = int'(ins[3:0]);
      ill   = 1'b0;
      expB  = 32'd0;
      expWd = 32'd0;
      if (op == 0) begin
         if (f inside {0, 1, 2, 3, 6, 7, 9}) expB = rtVal;
         else expB = 32'(ins[18:14]);
         expWd = aluRef(ins[3:0], aVal, expB);
      end else if (op == 1) begin
         immVal = longint'(ins[21:0]);
         if (immVal >= 64'sd2097152) immVal = immVal - 64'sd4194304;
         expB  = immVal[31:0];
         expWd = aluRef(ins[3:0], aVal, expB);
      end else begin
         ill = 1'b1;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] ins);
      instr_valid = 1'b1;
      instr       = ins;
   endtask

   // Every output at its idle/reset value
   task automatic checkIdle(input string tag);
      checkOutput({tag, ".ready"},   32'(instr_ready), 32'd1);
      checkOutput({tag, ".busy"},    32'(busy), 32'd0);
      checkOutput({tag, ".done"},    32'(done), 32'd0);
      checkOutput({tag, ".illegal"}, 32'(illegal), 32'd0);
      checkOutput({tag, ".rfWe"},    32'(rf_we), 32'd0);
      checkOutput({tag, ".rfWa"},    32'(rf_wa), 32'd0);
      checkOutput({tag, ".rfWd"},    rf_wd, 32'd0);
      checkOutput({tag, ".ra1"},     32'(rf_ra1), 32'd0);
      checkOutput({tag, ".ra2"},     32'(rf_ra2), 32'd0);
      checkOutput({tag, ".aluA"},    alu_a, 32'd0);
      checkOutput({tag, ".aluB"},    alu_b, 32'd0);
      checkOutput({tag, ".aluF"},    32'(alu_fcode), 32'd0);
   endtask

   // Loads rt first then rs so an aliased register reads back the rs value
   task automatic setupRegs(input logic [31:0] ins, input logic [31:0] rsVal, input logic [31:0] rtVal);
      rf[ins[23:19]] = rtVal;
      rf[ins[28:24]] = rsVal;
   endtask

   // Runs one instruction from an idle negedge and checks every cycle up to ready returning
   task automatic runVector(input string tag, input logic [31:0] ins, input logic [31:0] expB,
                            input logic [31:0] expWd, input logic ill);
      logic [31:0] aVal;
      aVal = rf[ins[28:24]];
      checkOutput({tag, ".c0ready"}, 32'(instr_ready), 32'd1);
      applyStimulus(ins);
      @(negedge clk);
      instr_valid = 1'b0;
      if (ill) begin
         checkOutput({tag, ".c1done"},    32'(done), 32'd1);
         checkOutput({tag, ".c1illegal"}, 32'(illegal), 32'd1);
         checkOutput({tag, ".c1rfWe"},    32'(rf_we), 32'd0);
         checkOutput({tag, ".c1ready"},   32'(instr_ready), 32'd0);
         @(negedge clk);
         checkOutput({tag, ".c2ready"},   32'(instr_ready), 32'd1);
         checkOutput({tag, ".c2done"},    32'(done), 32'd0);
         checkOutput({tag, ".c2rfWe"},    32'(rf_we), 32'd0);
      end else begin
         checkOutput({tag, ".c1busy"}, 32'(busy), 32'd1);
         checkOutput({tag, ".c1ra1"},  32'(rf_ra1), 32'(ins[28:24]));
         checkOutput({tag, ".c1ra2"},  32'(rf_ra2), 32'(ins[23:19]));
         checkOutput({tag, ".c1aluA"}, alu_a, 32'd0);
         checkOutput({tag, ".c1done"}, 32'(done), 32'd0);
         @(negedge clk);
         checkOutput({tag, ".c2aluA"}, alu_a, aVal);
         checkOutput({tag, ".c2aluB"}, alu_b, expB);
         checkOutput({tag, ".c2aluF"}, 32'(alu_fcode), 32'(ins[3:0]));
         checkOutput({tag, ".c2ra1"},  32'(rf_ra1), 32'd0);
         checkOutput({tag, ".c2rfWe"}, 32'(rf_we), 32'd0);
         @(negedge clk);
         checkOutput({tag, ".c3rfWe"},    32'(rf_we), 32'd1);
         checkOutput({tag, ".c3rfWa"},    32'(rf_wa), 32'(ins[28:24]));
         checkOutput({tag, ".c3rfWd"},    rf_wd, expWd);
         checkOutput({tag, ".c3done"},    32'(done), 32'd1);
         checkOutput({tag, ".c3illegal"}, 32'(illegal), 32'd0);
         checkOutput({tag, ".c3aluB"},    alu_b, 32'd0);
         @(negedge clk);
         checkOutput({tag, ".c4ready"}, 32'(instr_ready), 32'd1);
         checkOutput({tag, ".c4rfWe"},  32'(rf_we), 32'd0);
         checkOutput({tag, ".c4done"},  32'(done), 32'd0);
      end
   endtask

   // Main test sequence: reset, directed table, handshake and reset corners, random instructions
   initial begin
      logic [31:0] ins, rsVal, rtVal, expB, expWd, ins2;
      logic        ill;
      int          r;

      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
      rst         = 1'b1;
      instr_valid = 1'b0;
      instr       = 32'd0;

      vecs[0]  = '{mkR(0, 3, 4, 0, 0),      32'd5,          32'd7,          32'd7,          32'd12,         1'b0};
      vecs[1]  = '{mkI(1, 10, 'h3FFFFF),    32'd10,         32'd0,          32'hFFFFFFFF,   32'd9,          1'b0};
      vecs[2]  = '{mkR(0, 1, 2, 4, 4),      32'h1,          32'h55,         32'd4,          32'h10,         1'b0};
      vecs[3]  = '{mkR(0, 7, 8, 0, 1),      32'd20,         32'd3,          32'd3,          32'd17,         1'b0};
      vecs[4]  = '{mkR(0, 5, 6, 31, 5),     32'h80000000,   32'd9,          32'd31,         32'd1,          1'b0};
      vecs[5]  = '{mkI(1, 13, 'h000123),    32'h1000,       32'd0,          32'h123,        32'h1123,       1'b0};
      vecs[6]  = '{mkR(5, 1, 2, 0, 0),      32'd1,          32'd2,          32'd0,          32'd0,          1'b1};
      vecs[7]  = '{mkR(2, 3, 4, 0, 0),      32'd1,          32'd2,          32'd0,          32'd0,          1'b1};
      vecs[8]  = '{mkR(0, 9, 10, 0, 6),     32'hFF00FF00,   32'h0F0F0F0F,   32'h0F0F0F0F,   32'hF00FF00F,   1'b0};
      vecs[9]  = '{mkI(1, 11, 'h1FFFFF),    32'd1,          32'd0,          32'h001FFFFF,   32'h00200000,   1'b0};
      vecs[10] = '{mkI(1, 12, 'h200000),    32'h00200000,   32'd0,          32'hFFE00000,   32'd0,          1'b0};
      vecs[11] = '{mkR(0, 14, 15, 0, 9),    32'hFFFFFFFF,   32'd1,          32'd1,          32'd1,          1'b0};
      vecs[12] = '{mkR(0, 16, 17, 0, 5),    32'hABCD,       32'd3,          32'd0,          32'hABCD,       1'b0};
      vecs[13] = '{mkR(7, 20, 21, 3, 2),    32'd1,          32'd2,          32'd0,          32'd0,          1'b1};

      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkIdle("reset");

      for (int i = 0; i < 14; i++) begin
         setupRegs(vecs[i].ins, vecs[i].rsVal, vecs[i].rtVal);
         runVector($sformatf("vec%0d", i), vecs[i].ins, vecs[i].expB, vecs[i].expWd, vecs[i].ill);
      end

      // Back-to-back: valid stays high, second word must wait for the next IDLE cycle
      rf[3] = 32'd5;   rf[4] = 32'd7;
      rf[8] = 32'd100; rf[9] = 32'd1;
      ins  = mkR(0, 3, 4, 0, 0);
      ins2 = mkR(0, 8, 9, 0, 1);
      applyStimulus(ins);
      @(negedge clk);
      instr = ins2;
      checkOutput("b2b.c1ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      checkOutput("b2b.c2ready", 32'(instr_ready), 32'd0);
      @(negedge clk);
      checkOutput("b2b.c3ready", 32'(instr_ready), 32'd0);
      checkOutput("b2b.c3rfWd",  rf_wd, 32'd12);
      @(negedge clk);
      checkOutput("b2b.c4ready", 32'(instr_ready), 32'd1);
      checkOutput("b2b.c4done",  32'(done), 32'd0);
      @(negedge clk);
      instr_valid = 1'b0;
      checkOutput("b2b.c5busy", 32'(busy), 32'd1);
      checkOutput("b2b.c5ra1",  32'(rf_ra1), 32'd8);
      @(negedge clk);
      checkOutput("b2b.c6aluA", alu_a, 32'd100);
      @(negedge clk);
      checkOutput("b2b.c7rfWe", 32'(rf_we), 32'd1);
      checkOutput("b2b.c7rfWa", 32'(rf_wa), 32'd8);
      checkOutput("b2b.c7rfWd", rf_wd, 32'd99);
      @(negedge clk);
      checkOutput("b2b.c8ready", 32'(instr_ready), 32'd1);

      // Reset pulsed during READ and during EXEC: outputs clear at once and no write follows
      for (int k = 1; k <= 2; k++) begin
         rf[5] = 32'h1234; rf[6] = 32'h1;
         applyStimulus(mkR(0, 5, 6, 0, 0));
         @(negedge clk);
         instr_valid = 1'b0;
         if (k == 2) @(negedge clk);
         checkOutput($sformatf("rst%0d.preBusy", k), 32'(busy), 32'd1);
         rst = 1'b1;
         #1;
         checkIdle($sformatf("rst%0d.async", k));
         @(negedge clk);
         rst = 1'b0;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("rst%0d.noWe%0d", k, c), 32'(rf_we), 32'd0);
            checkOutput($sformatf("rst%0d.noDone%0d", k, c), 32'(done), 32'd0);
         end
         setupRegs(vecs[0].ins, vecs[0].rsVal, vecs[0].rtVal);
         runVector($sformatf("rst%0d.after", k), vecs[0].ins, vecs[0].expB, vecs[0].expWd, vecs[0].ill);
      end

      // Random instructions, biased towards the ALU classes
      for (int n = 0; n < 60; n++) begin
         ins = $urandom;
         r = int'($urandom_range(0, 9));
         if (r < 4)      ins[31:29] = 3'd0;
         else if (r < 7) ins[31:29] = 3'd1;
         else            ins[31:29] = 3'($urandom_range(2, 7));
         setupRegs(ins, $urandom, $urandom);
         rsVal = rf[ins[28:24]];
         rtVal = rf[ins[23:19]];
         refModel(ins, rsVal, rtVal, expB, expWd, ill);
         runVector($sformatf("rnd%0d", n), ins, expB, expWd, ill);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
